// File: rtl/pspin_hostmem_dma_rd.sv
// Read path of the PsPIN host-memory DMA adapter: one AXI read burst becomes one
// DMA read descriptor, then the staged data is streamed from the DMA RAM onto R.
module pspin_hostmem_dma_rd #(
    parameter int DMA_LEN_WIDTH      = 16,
    parameter int DMA_TAG_WIDTH      = 16,
    parameter int RAM_SEL_WIDTH      = 4,
    parameter int RAM_ADDR_WIDTH     = 20,
    parameter int RAM_SEG_COUNT      = 2,
    parameter int RAM_SEG_DATA_WIDTH = 256,
    parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH/8),
    parameter int ADDR_WIDTH         = 64,
    parameter int DATA_WIDTH         = 512,
    parameter int STRB_WIDTH         = DATA_WIDTH/8,
    parameter int ID_WIDTH           = 8,
    parameter int ARUSER_WIDTH       = 1,
    parameter int RUSER_WIDTH        = 1
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    output logic [ADDR_WIDTH-1:0]                        m_axis_read_desc_dma_addr,
    output logic [RAM_SEL_WIDTH-1:0]                     m_axis_read_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]                    m_axis_read_desc_ram_addr,
    output logic [DMA_LEN_WIDTH-1:0]                     m_axis_read_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]                     m_axis_read_desc_tag,
    output logic                                         m_axis_read_desc_valid,
    input  logic                                         m_axis_read_desc_ready,
    input  logic [DMA_TAG_WIDTH-1:0]                     s_axis_read_desc_status_tag,
    input  logic [3:0]                                   s_axis_read_desc_status_error,
    input  logic                                         s_axis_read_desc_status_valid,
    output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  ram_rd_cmd_addr,
    output logic [RAM_SEG_COUNT-1:0]                     ram_rd_cmd_valid,
    input  logic [RAM_SEG_COUNT-1:0]                     ram_rd_cmd_ready,
    input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  ram_rd_resp_data,
    input  logic [RAM_SEG_COUNT-1:0]                     ram_rd_resp_valid,
    output logic [RAM_SEG_COUNT-1:0]                     ram_rd_resp_ready,
    input  logic [ID_WIDTH-1:0]                          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]                        s_axi_araddr,
    input  logic [7:0]                                   s_axi_arlen,
    input  logic [2:0]                                   s_axi_arsize,
    input  logic [1:0]                                   s_axi_arburst,
    input  logic                                         s_axi_arlock,
    input  logic [3:0]                                   s_axi_arcache,
    input  logic [2:0]                                   s_axi_arprot,
    input  logic [3:0]                                   s_axi_arqos,
    input  logic [3:0]                                   s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0]                      s_axi_aruser,
    input  logic                                         s_axi_arvalid,
    output logic                                         s_axi_arready,
    output logic [ID_WIDTH-1:0]                          s_axi_rid,
    output logic [DATA_WIDTH-1:0]                        s_axi_rdata,
    output logic [1:0]                                   s_axi_rresp,
    output logic                                         s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]                       s_axi_ruser,
    output logic                                         s_axi_rvalid,
    input  logic                                         s_axi_rready,
    output logic [2:0]                                   dbg_state
);

    typedef enum logic [2:0] {IDLE, DESC, WAIT, READ, ERR} state_t;

    localparam int         SIZE_LOG = $clog2(STRB_WIDTH);
    localparam logic [2:0] AXI_SIZE = 3'(SIZE_LOG);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Every channel uses valid/ready: a transfer happens on a rising clk edge where
    // both are high; a raised valid and its payload stay put until that transfer.
    state_t                              state;
    logic [ID_WIDTH-1:0]                 id_q;
    logic [ADDR_WIDTH-1:0]               addr_q;
    logic [7:0]                          len_q;
    logic [DMA_TAG_WIDTH-1:0]            tag_cnt;
    logic [DMA_TAG_WIDTH-1:0]            cur_tag;
    logic [RAM_SEG_COUNT-1:0][8:0]       cmd_cnt;
    logic [8:0]                          beat_cnt;
    logic                                desc_valid_q;
    logic                                arready_q;
    logic                                rvalid_q;
    logic                                rlast_q;
    logic [1:0]                          rresp_q;
    logic [DATA_WIDTH-1:0]               rdata_q;
    logic [ID_WIDTH-1:0]                 rid_q;

    logic ar_fire, ar_bad, desc_fire, status_hit, slot_free, beats_left;
    logic resp_fire, err_beat, r_done, last_beat;

    assign ar_fire    = s_axi_arvalid && arready_q;
    assign ar_bad     = (s_axi_arburst != 2'b01) || (s_axi_arsize != AXI_SIZE) ||
                        (s_axi_araddr[SIZE_LOG-1:0] != '0);
    assign desc_fire  = desc_valid_q && m_axis_read_desc_ready;
    assign status_hit = (state == WAIT) && s_axis_read_desc_status_valid &&
                        (s_axis_read_desc_status_tag == cur_tag);
    assign slot_free  = !rvalid_q || s_axi_rready;
    assign beats_left = beat_cnt <= {1'b0, len_q};
    assign last_beat  = beat_cnt == {1'b0, len_q};
    // A RAM word is only consumed when every segment has its half ready at once.
    assign resp_fire  = (state == READ) && (&ram_rd_resp_valid) && slot_free && beats_left;
    assign err_beat   = (state == ERR) && slot_free && beats_left;
    assign r_done     = rvalid_q && s_axi_rready && rlast_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            tag_cnt      <= '0;
            cur_tag      <= '0;
            cmd_cnt      <= '0;
            beat_cnt     <= '0;
            desc_valid_q <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            rid_q        <= '0;
        end else begin
            if (s_axi_rready) rvalid_q <= 1'b0;
            if (r_done) begin
                state     <= IDLE;
                arready_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        id_q      <= s_axi_arid;
                        addr_q    <= s_axi_araddr;
                        len_q     <= s_axi_arlen;
                        arready_q <= 1'b0;
                        cmd_cnt   <= '0;
                        if (ar_bad) begin
                            state    <= ERR;
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            rresp_q  <= RESP_SLVERR;
                            rlast_q  <= (s_axi_arlen == 8'd0);
                            rid_q    <= s_axi_arid;
                            beat_cnt <= 9'd1;
                        end else begin
                            state        <= DESC;
                            desc_valid_q <= 1'b1;
                            beat_cnt     <= 9'd0;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                DESC: begin
                    if (desc_fire) begin
                        desc_valid_q <= 1'b0;
                        cur_tag      <= tag_cnt;
                        tag_cnt      <= tag_cnt + 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // Stale completions from earlier tags fall through here unseen.
                    if (status_hit) begin
                        if (s_axis_read_desc_status_error == 4'd0) begin
                            state <= READ;
                        end else begin
                            state    <= ERR;
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            rresp_q  <= RESP_SLVERR;
                            rlast_q  <= (len_q == 8'd0);
                            rid_q    <= id_q;
                            beat_cnt <= 9'd1;
                        end
                    end
                end
                READ: begin
                    for (int s = 0; s < RAM_SEG_COUNT; s++) begin
                        if (ram_rd_cmd_valid[s] && ram_rd_cmd_ready[s])
                            cmd_cnt[s] <= cmd_cnt[s] + 9'd1;
                    end
                    if (resp_fire) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= ram_rd_resp_data;
                        rresp_q  <= RESP_OKAY;
                        rlast_q  <= last_beat;
                        rid_q    <= id_q;
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                end
                ERR: begin
                    if (err_beat) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rlast_q  <= last_beat;
                        rid_q    <= id_q;
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each segment walks the word addresses 0..arlen at its own pace.
    for (genvar g = 0; g < RAM_SEG_COUNT; g++) begin : g_seg
        assign ram_rd_cmd_addr[g*RAM_SEG_ADDR_WIDTH +: RAM_SEG_ADDR_WIDTH] = RAM_SEG_ADDR_WIDTH'(cmd_cnt[g]);
        assign ram_rd_cmd_valid[g] = (state == READ) && (cmd_cnt[g] <= {1'b0, len_q});
    end
    assign ram_rd_resp_ready = {RAM_SEG_COUNT{resp_fire}};

    assign m_axis_read_desc_dma_addr = addr_q;
    assign m_axis_read_desc_ram_sel  = '0;
    assign m_axis_read_desc_ram_addr = '0;
    assign m_axis_read_desc_len      = DMA_LEN_WIDTH'((32'(len_q) + 32'd1) * 32'(STRB_WIDTH));
    assign m_axis_read_desc_tag      = tag_cnt;
    assign m_axis_read_desc_valid    = desc_valid_q;

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_ruser   = '0;
    assign s_axi_rvalid  = rvalid_q;
    assign dbg_state     = state;

    wire unused_ar = &{1'b0, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_arregion, s_axi_aruser};

endmodule
